// File: rtl/wb_stream_arb2.sv
// rtl/wb_stream_arb2.sv - two-requester Wishbone arbiter with round-robin tie-break and burst hold
module wb_stream_arb2 #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,

    input  logic [WB_AW-1:0]   wbs0_adr_i,
    input  logic [WB_DW-1:0]   wbs0_dat_i,
    input  logic [WB_DW/8-1:0] wbs0_sel_i,
    input  logic               wbs0_we_i,
    input  logic               wbs0_cyc_i,
    input  logic               wbs0_stb_i,
    input  logic [2:0]         wbs0_cti_i,
    input  logic [1:0]         wbs0_bte_i,
    output logic [WB_DW-1:0]   wbs0_dat_o,
    output logic               wbs0_ack_o,
    output logic               wbs0_err_o,
    output logic               wbs0_rty_o,

    input  logic [WB_AW-1:0]   wbs1_adr_i,
    input  logic [WB_DW-1:0]   wbs1_dat_i,
    input  logic [WB_DW/8-1:0] wbs1_sel_i,
    input  logic               wbs1_we_i,
    input  logic               wbs1_cyc_i,
    input  logic               wbs1_stb_i,
    input  logic [2:0]         wbs1_cti_i,
    input  logic [1:0]         wbs1_bte_i,
    output logic [WB_DW-1:0]   wbs1_dat_o,
    output logic               wbs1_ack_o,
    output logic               wbs1_err_o,
    output logic               wbs1_rty_o,

    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,

    output logic [1:0]         grant_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_GNT0 = 2'b01,
        S_GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   end0, end1;

    // A burst ends on a terminating ack, any abort, or the owner abandoning the cycle.
    assign end0 = !wbs0_cyc_i || wbm_err_i || wbm_rty_i ||
                  (wbm_ack_i && (wbs0_cti_i == 3'b000 || wbs0_cti_i == 3'b111));
    assign end1 = !wbs1_cyc_i || wbm_err_i || wbm_rty_i ||
                  (wbm_ack_i && (wbs1_cti_i == 3'b000 || wbs1_cti_i == 3'b111));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = S_IDLE;
        last_owner_d = last_owner_q;
        case (state_q)
            S_IDLE: begin
                if (wbs0_cyc_i && wbs1_cyc_i)
                    state_d = last_owner_q ? S_GNT0 : S_GNT1;
                else if (wbs0_cyc_i)
                    state_d = S_GNT0;
                else if (wbs1_cyc_i)
                    state_d = S_GNT1;
                else
                    state_d = S_IDLE;
            end
            S_GNT0: begin
                if (end0) begin
                    state_d      = S_IDLE;
                    last_owner_d = 1'b0;
                end else begin
                    state_d = S_GNT0;
                end
            end
            S_GNT1: begin
                if (end1) begin
                    state_d      = S_IDLE;
                    last_owner_d = 1'b1;
                end else begin
                    state_d = S_GNT1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_sel_o = '0;
        wbm_we_o  = 1'b0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_cti_o = 3'b000;
        wbm_bte_o = 2'b00;
        case (state_q)
            S_GNT0: begin
                wbm_adr_o = wbs0_adr_i;
                wbm_dat_o = wbs0_dat_i;
                wbm_sel_o = wbs0_sel_i;
                wbm_we_o  = wbs0_we_i;
                wbm_cyc_o = wbs0_cyc_i;
                wbm_stb_o = wbs0_stb_i;
                wbm_cti_o = wbs0_cti_i;
                wbm_bte_o = wbs0_bte_i;
            end
            S_GNT1: begin
                wbm_adr_o = wbs1_adr_i;
                wbm_dat_o = wbs1_dat_i;
                wbm_sel_o = wbs1_sel_i;
                wbm_we_o  = wbs1_we_i;
                wbm_cyc_o = wbs1_cyc_i;
                wbm_stb_o = wbs1_stb_i;
                wbm_cti_o = wbs1_cti_i;
                wbm_bte_o = wbs1_bte_i;
            end
            default: ;
        endcase
    end

    assign wbs0_dat_o = wbm_dat_i;
    assign wbs1_dat_o = wbm_dat_i;
    assign wbs0_ack_o = (state_q == S_GNT0) && wbm_ack_i;
    assign wbs0_err_o = (state_q == S_GNT0) && wbm_err_i;
    assign wbs0_rty_o = (state_q == S_GNT0) && wbm_rty_i;
    assign wbs1_ack_o = (state_q == S_GNT1) && wbm_ack_i;
    assign wbs1_err_o = (state_q == S_GNT1) && wbm_err_i;
    assign wbs1_rty_o = (state_q == S_GNT1) && wbm_rty_i;

    assign grant_o = {state_q == S_GNT1, state_q == S_GNT0};

endmodule

// File: tb/tb_wb_stream_arb2.sv
// tb/tb_wb_stream_arb2.sv - directed vector bench for wb_stream_arb2
module tb_wb_stream_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s0_adr, s0_dat, s1_adr, s1_dat;
    logic [3:0]  s0_sel, s1_sel;
    logic        s0_we, s0_cyc, s0_stb, s1_we, s1_cyc, s1_stb;
    logic [2:0]  s0_cti, s1_cti;
    logic [1:0]  s0_bte, s1_bte;
    logic [31:0] s0_dato, s1_dato;
    logic        s0_ack, s0_err, s0_rty, s1_ack, s1_err, s1_rty;
    logic [31:0] m_adr, m_dato, m_dati;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb, m_ack, m_err, m_rty;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stream_arb2 #(.WB_AW(32), .WB_DW(32)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs0_adr_i(s0_adr), .wbs0_dat_i(s0_dat), .wbs0_sel_i(s0_sel), .wbs0_we_i(s0_we),
        .wbs0_cyc_i(s0_cyc), .wbs0_stb_i(s0_stb), .wbs0_cti_i(s0_cti), .wbs0_bte_i(s0_bte),
        .wbs0_dat_o(s0_dato), .wbs0_ack_o(s0_ack), .wbs0_err_o(s0_err), .wbs0_rty_o(s0_rty),
        .wbs1_adr_i(s1_adr), .wbs1_dat_i(s1_dat), .wbs1_sel_i(s1_sel), .wbs1_we_i(s1_we),
        .wbs1_cyc_i(s1_cyc), .wbs1_stb_i(s1_stb), .wbs1_cti_i(s1_cti), .wbs1_bte_i(s1_bte),
        .wbs1_dat_o(s1_dato), .wbs1_ack_o(s1_ack), .wbs1_err_o(s1_err), .wbs1_rty_o(s1_rty),
        .wbm_adr_o(m_adr), .wbm_dat_o(m_dato), .wbm_sel_o(m_sel), .wbm_we_o(m_we),
        .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb), .wbm_cti_o(m_cti), .wbm_bte_o(m_bte),
        .wbm_dat_i(m_dati), .wbm_ack_i(m_ack), .wbm_err_i(m_err), .wbm_rty_i(m_rty),
        .grant_o(grant)
    );

    typedef struct {
        logic        c0, c1;
        logic [2:0]  cti0, cti1;
        logic        ack, err, rty;
        logic [1:0]  e_gnt;
        logic        e_cyc;
        logic [31:0] e_adr;
        logic        e_ack0, e_ack1, e_err0, e_err1, e_rty0;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c0, input logic c1, input logic [2:0] t0, input logic [2:0] t1,
                         input logic a, input logic e, input logic r);
        s0_cyc = c0; s0_stb = c0; s0_cti = t0;
        s1_cyc = c1; s1_stb = c1; s1_cti = t1;
        m_ack = a; m_err = e; m_rty = r;
    endtask

    initial begin
        rst = 1'b1;
        s0_adr = 32'h100; s0_dat = 32'hA0A0; s0_sel = 4'hF; s0_we = 1'b0; s0_bte = 2'b00;
        s1_adr = 32'h200; s1_dat = 32'hB1B1; s1_sel = 4'h3; s1_we = 1'b1; s1_bte = 2'b01;
        m_dati = 32'hCAFE_0042;
        drive(0, 0, 0, 0, 0, 0, 0);

        //            c0 c1 t0 t1 a e r  gnt   cyc adr    a0 a1 e0 e1 r0
        vecs.push_back(vec_t'{1, 1, 2, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 2, 0, 1, 0, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 2, 0, 1, 0, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 2, 0, 1, 0, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 7, 0, 1, 0, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 1, 0, 0, 1, 0, 0, 2'b10, 1, 32'h200, 0, 1, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 0, 2, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 0, 2, 0, 1, 0, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 2, 0, 0, 1, 0, 2'b01, 1, 32'h100, 0, 0, 1, 0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 1, 0, 2, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 1, 0, 2, 1, 0, 0, 2'b10, 1, 32'h200, 0, 1, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 2, 0, 0, 0, 2'b10, 0, 32'h200, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 2'b10, 1, 32'h200, 0, 1, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 2'b01, 1, 32'h100, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 0, 2, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 0, 2, 0, 0, 0, 1, 2'b01, 1, 32'h100, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0, 0, 0});

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_grant", {30'd0, grant}, 32'd0);
        chk("reset_cyc", {31'd0, m_cyc}, 32'd0);
        chk("bcast_dat0", s0_dato, 32'hCAFE_0042);
        chk("bcast_dat1", s1_dato, 32'hCAFE_0042);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].c0, vecs[i].c1, vecs[i].cti0, vecs[i].cti1,
                  vecs[i].ack, vecs[i].err, vecs[i].rty);
            #2;
            chk($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vecs[i].e_gnt});
            chk($sformatf("v%0d_cyc", i), {31'd0, m_cyc}, {31'd0, vecs[i].e_cyc});
            chk($sformatf("v%0d_adr", i), m_adr, vecs[i].e_adr);
            chk($sformatf("v%0d_ack0", i), {31'd0, s0_ack}, {31'd0, vecs[i].e_ack0});
            chk($sformatf("v%0d_ack1", i), {31'd0, s1_ack}, {31'd0, vecs[i].e_ack1});
            chk($sformatf("v%0d_err0", i), {31'd0, s0_err}, {31'd0, vecs[i].e_err0});
            chk($sformatf("v%0d_err1", i), {31'd0, s1_err}, {31'd0, vecs[i].e_err1});
            chk($sformatf("v%0d_rty0", i), {31'd0, s0_rty}, {31'd0, vecs[i].e_rty0});
            @(negedge clk);
        end

        // 8-beat burst by requester 1; requester 0 joins at beat 2 and must wait.
        drive(0, 1, 0, 3'b010, 0, 0, 0);
        @(negedge clk);
        for (int b = 1; b <= 8; b++) begin
            drive(b >= 2, 1, 0, (b == 8) ? 3'b111 : 3'b010, 1, 0, 0);
            #2;
            chk($sformatf("burst8_b%0d_grant", b), {30'd0, grant}, 32'd2);
            chk($sformatf("burst8_b%0d_ack1", b), {31'd0, s1_ack}, 32'd1);
            chk($sformatf("burst8_b%0d_ack0", b), {31'd0, s0_ack}, 32'd0);
            @(negedge clk);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        #2;
        chk("burst8_idle_gap", {30'd0, grant}, 32'd0);
        @(negedge clk);
        #2;
        chk("burst8_then_r0", {30'd0, grant}, 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("abandon_idle", {30'd0, grant}, 32'd0);
        @(negedge clk);

        // Reset during beat 3 of a requester-1 burst; last owner is 0 beforehand.
        drive(0, 1, 0, 3'b010, 0, 0, 0);
        @(negedge clk);
        for (int b = 1; b <= 3; b++) begin
            drive(0, 1, 0, 3'b010, 1, 0, 0);
            rst = (b == 3);
            #2;
            chk($sformatf("rstb_b%0d_grant", b), {30'd0, grant}, 32'd2);
            @(negedge clk);
        end
        rst = 1'b0;
        drive(1, 1, 3'b010, 3'b010, 1, 0, 0);
        #2;
        chk("rst_cyc_drop", {31'd0, m_cyc}, 32'd0);
        chk("rst_stb_drop", {31'd0, m_stb}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_no_ack1", {31'd0, s1_ack}, 32'd0);
        chk("rst_no_ack0", {31'd0, s0_ack}, 32'd0);
        @(negedge clk);
        #2;
        chk("rst_tie_r0", {30'd0, grant}, 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
